// File: rtl/hdc_pkg.sv
// Shared types and constants for the hypervector bundling datapath.
package hdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        FIRE,
        WAIT,
        WRITE,
        FIN
    } bundle_seq_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] BUNDLE_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] BUNDLE_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/hv_bundle_seq_tie_lfsr.sv
// 16-bit Fibonacci LFSR that yields two tie-break bits and advances only when stepped.
module tie_lfsr
    import hdc_pkg::*;
#(
    parameter logic [15:0] SEED = BUNDLE_LFSR_SEED
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       step,
    output logic [1:0] tie
);

    logic [15:0] state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[14:0], ^(state & BUNDLE_LFSR_TAPS)};
        end
    end

    assign tie = state[1:0];

endmodule

// File: rtl/hv_bundle_seq.sv
// Walks every dimension of an HV set: read bits, fire the bundler, wait for its result, write it back.
module hv_bundle_seq
    import hdc_pkg::*;
#(
    parameter int          NUM_HVS   = 5,
    parameter int          DIM       = 256,
    parameter int          ADDR_W    = $clog2(DIM),
    parameter logic [15:0] LFSR_SEED = BUNDLE_LFSR_SEED
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_bits [NUM_HVS-1:0],
    output logic              bnd_en,
    output logic              bnd_bits [NUM_HVS-1:0],
    output logic              bnd_tie_1,
    output logic              bnd_tie_2,
    input  logic              bnd_done,
    input  logic              bnd_out_bit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_bit
);

    bundle_seq_state_t state, state_nx;

    logic [ADDR_W-1:0] dim_cnt;
    logic              last_dim;
    logic              bits_hold [NUM_HVS-1:0];
    logic [1:0]        tie_hold;
    logic [1:0]        tie_now;
    logic              res_bit;
    logic              lfsr_step;

    assign last_dim  = (dim_cnt == ADDR_W'(DIM - 1));
    assign lfsr_step = (state == FIRE) && !abort;

    tie_lfsr #(
        .SEED (LFSR_SEED)
    ) u_tie_lfsr (
        .clk  (clk),
        .nrst (nrst),
        .step (lfsr_step),
        .tie  (tie_now)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == FIN);
        rd_en    = (state == READ);
        bnd_en   = (state == FIRE);
        wr_en    = (state == WRITE);
        case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    state_nx = FIRE;
            FIRE:    state_nx = WAIT;
            WAIT:    if (bnd_done) state_nx = WRITE;
            WRITE:   state_nx = last_dim ? FIN : READ;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort overrides every transition, including a start seen in IDLE.
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dim_cnt  <= '0;
            tie_hold <= '0;
            res_bit  <= 1'b0;
            for (int i = 0; i < NUM_HVS; i++) bits_hold[i] <= 1'b0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                dim_cnt <= '0;
            end else if (state == WRITE && !last_dim) begin
                dim_cnt <= dim_cnt + 1'b1;
            end
            if (state == FIRE) begin
                tie_hold <= tie_now;
                for (int i = 0; i < NUM_HVS; i++) bits_hold[i] <= rd_bits[i];
            end
            if (state == WAIT && bnd_done) begin
                res_bit <= bnd_out_bit;
            end
        end
    end

    // Read data arrives during FIRE, so the bundler sees it directly then and the held copy afterwards.
    always_comb begin
        for (int i = 0; i < NUM_HVS; i++) begin
            bnd_bits[i] = (state == FIRE) ? rd_bits[i] : bits_hold[i];
        end
        bnd_tie_1 = (state == FIRE) ? tie_now[0] : tie_hold[0];
        bnd_tie_2 = (state == FIRE) ? tie_now[1] : tie_hold[1];
    end

    assign rd_addr = dim_cnt;
    assign wr_addr = dim_cnt;
    assign wr_bit  = res_bit;

endmodule

// File: tb/tb_hv_bundle_seq.sv
// Bench for hv_bundle_seq: odd- and even-count instances with behavioural HV buffer and bundler models.
module tb_hv_bundle_seq;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [4:0]  HV5  = 5'b01011;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Five-input instance.
    logic       start5, abort5, busy5, done5, rd_en5, bnd_en5, tie1_5, tie2_5;
    logic       bnd_done5, bnd_out5, wr_en5, wr_bit5;
    logic [1:0] rd_addr5, wr_addr5;
    logic       rd_bits5  [4:0];
    logic       bnd_bits5 [4:0];
    logic [4:0] bb5;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rd_bits5[i] = HV5[i];
            bb5[i]      = bnd_bits5[i];
        end
    end

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bnd_done5 <= 1'b0;
            bnd_out5  <= 1'b0;
        end else begin
            bnd_done5 <= bnd_en5;
            if (bnd_en5) bnd_out5 <= ($countones(bb5) >= 3);
        end
    end

    hv_bundle_seq #(.NUM_HVS(5), .DIM(4)) u5 (
        .clk(clk), .nrst(nrst), .start(start5), .abort(abort5), .busy(busy5), .done(done5),
        .rd_en(rd_en5), .rd_addr(rd_addr5), .rd_bits(rd_bits5), .bnd_en(bnd_en5),
        .bnd_bits(bnd_bits5), .bnd_tie_1(tie1_5), .bnd_tie_2(tie2_5), .bnd_done(bnd_done5),
        .bnd_out_bit(bnd_out5), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_bit(wr_bit5)
    );

    // Four-input instance, where ties are possible.
    logic       start4, abort4, busy4, done4, rd_en4, bnd_en4, tie1_4, tie2_4;
    logic       bnd_done4, bnd_out4, wr_en4, wr_bit4;
    logic [1:0] rd_addr4, wr_addr4;
    logic       rd_bits4  [3:0];
    logic       bnd_bits4 [3:0];
    logic [3:0] bb4, rd_data4;
    logic [3:0] hv_mem [0:3];
    int         delay4 = 1;
    int         cnt4;
    logic       done_m4, res4, spur4, spur_on;

    function automatic logic resolve4(input logic [3:0] b, input logic t);
        int n;
        n = $countones(b);
        if (n > 2) return 1'b1;
        if (n < 2) return 1'b0;
        return t;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_bits4[i] = rd_data4[i];
            bb4[i]      = bnd_bits4[i];
        end
    end

    always @(posedge clk) if (rd_en4) rd_data4 <= hv_mem[rd_addr4];

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done_m4 <= 1'b0;
            cnt4    <= 0;
            res4    <= 1'b0;
        end else begin
            done_m4 <= (bnd_en4 && delay4 == 1) || (!bnd_en4 && cnt4 == 2);
            if (bnd_en4) begin
                cnt4 <= delay4;
                res4 <= resolve4(bb4, tie1_4);
            end else if (cnt4 != 0) begin
                cnt4 <= cnt4 - 1;
            end
        end
    end

    assign bnd_done4 = done_m4 | spur4;
    assign bnd_out4  = res4;

    hv_bundle_seq #(.NUM_HVS(4), .DIM(4)) u4 (
        .clk(clk), .nrst(nrst), .start(start4), .abort(abort4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_bits(rd_bits4), .bnd_en(bnd_en4),
        .bnd_bits(bnd_bits4), .bnd_tie_1(tie1_4), .bnd_tie_2(tie2_4), .bnd_done(bnd_done4),
        .bnd_out_bit(bnd_out4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_bit(wr_bit4)
    );

    // Observation of the four-input instance at the falling edge.
    int         cyc = 0;
    int         wc_q [$];
    logic [1:0] wa_q [$];
    logic       wb_q [$];
    logic       t1_q [$];
    logic       t2_q [$];
    logic [3:0] held4;
    int         unstable = 0, excl_err = 0, done_cnt4 = 0, strobe_cnt4 = 0;
    logic       p_rd = 1'b0, p_bnd = 1'b0, p_wr = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en4) begin
            wa_q.push_back(wr_addr4);
            wb_q.push_back(wr_bit4);
            wc_q.push_back(cyc);
        end
        if (bnd_en4) begin
            t1_q.push_back(tie1_4);
            t2_q.push_back(tie2_4);
            held4 <= bb4;
        end else if (busy4 && bb4 !== held4) begin
            unstable <= unstable + 1;
        end
        if ($countones({rd_en4, bnd_en4, wr_en4}) > 1 ||
            (rd_en4 && p_rd) || (bnd_en4 && p_bnd) || (wr_en4 && p_wr))
            excl_err <= excl_err + 1;
        if (rd_en4 || bnd_en4 || wr_en4) strobe_cnt4 <= strobe_cnt4 + 1;
        if (done4) done_cnt4 <= done_cnt4 + 1;
        p_rd  <= rd_en4;
        p_bnd <= bnd_en4;
        p_wr  <= wr_en4;
        spur4 <= spur_on && rd_en4;
    end

    logic [15:0] ref_lfsr;

    task automatic run4(input int maxc, output int n, output bit got);
        n   = 1;
        got = 1'b0;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        while (!got && n < maxc) begin
            if (done4) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int s5;
        nrst = 1'b0;
        {start5, abort5, start4, abort4, spur_on} = '0;
        for (int a = 0; a < 4; a++) hv_mem[a] = 4'h0;
        #100;
        checks++;
        if ({busy4, done4, rd_en4, bnd_en4, wr_en4, tie1_4, tie2_4, wr_bit4, rd_addr4, wr_addr4, bb4} !== '0) begin
            errors++;
            $display("FAIL reset_u4: got %b required 0",
                     {busy4, done4, rd_en4, bnd_en4, wr_en4, tie1_4, tie2_4, wr_bit4, rd_addr4, wr_addr4, bb4});
        end
        checks++;
        if ({busy5, done5, rd_en5, bnd_en5, wr_en5, tie1_5, tie2_5, wr_bit5, rd_addr5, wr_addr5, bb5} !== '0) begin
            errors++;
            $display("FAIL reset_u5: got %b required 0",
                     {busy5, done5, rd_en5, bnd_en5, wr_en5, tie1_5, tie2_5, wr_bit5, rd_addr5, wr_addr5, bb5});
        end
        @(negedge clk) nrst = 1'b1;
        ref_lfsr = SEED;
        s5 = 0;
        begin
            int base;
            base = strobe_cnt4;
            repeat (20) begin
                @(negedge clk);
                if (rd_en5 || bnd_en5 || wr_en5 || busy5 || done5) s5++;
            end
            checks++;
            if (strobe_cnt4 - base != 0 || busy4 || done_cnt4 != 0) begin
                errors++;
                $display("FAIL idle_u4: strobes %0d busy %b dones %0d required 0",
                         strobe_cnt4 - base, busy4, done_cnt4);
            end
        end
        checks++;
        if (s5 != 0) begin
            errors++;
            $display("FAIL idle_u5: active cycles %0d required 0", s5);
        end
    endtask

    task automatic test_odd_majority();
        int n, wr_i, last;
        bit got, extra_seen;
        n = 1; wr_i = 0; last = 0; got = 1'b0; extra_seen = 1'b0;
        @(negedge clk) start5 = 1'b1;
        while (n < 60 && !got) begin
            @(negedge clk);
            start5 = 1'b0;
            n++;
            if (wr_en5) begin
                checks++;
                if (wr_addr5 !== 2'(wr_i) || wr_bit5 !== 1'b1) begin
                    errors++;
                    $display("FAIL odd_write: addr %0d bit %b required addr %0d bit 1", wr_addr5, wr_bit5, wr_i);
                end
                if (wr_i > 0) begin
                    checks++;
                    if (n - last != 4) begin
                        errors++;
                        $display("FAIL odd_dim_cycles: got %0d required 4", n - last);
                    end
                end
                last = n;
                wr_i++;
            end
            if (done5) got = 1'b1;
        end
        checks++;
        if (!got || n != 18) begin
            errors++;
            $display("FAIL odd_done_latency: got %0d (done seen %b) required 18", n, got);
        end
        checks++;
        if (wr_i != 4) begin
            errors++;
            $display("FAIL odd_write_count: got %0d required 4", wr_i);
        end
        repeat (10) begin
            @(negedge clk);
            if (done5 || busy5) extra_seen = 1'b1;
        end
        checks++;
        if (extra_seen) begin
            errors++;
            $display("FAIL odd_single_done: extra done/busy seen %b required 0", extra_seen);
        end
    endtask

    // Checks one full four-dimension pass against the reference tie sequence.
    task automatic test_ties();
        int bw, bt, bd, n;
        bit got;
        logic e1, e2;
        for (int a = 0; a < 4; a++) hv_mem[a] = 4'b0011;
        delay4 = 1;
        bw = wa_q.size(); bt = t1_q.size(); bd = done_cnt4;
        run4(100, n, got);
        checks++;
        if (!got || wa_q.size() != bw + 4 || t1_q.size() != bt + 4 || done_cnt4 != bd + 1) begin
            errors++;
            $display("FAIL ties_pass: done %b writes %0d fires %0d dones %0d required 1 4 4 1",
                     got, wa_q.size() - bw, t1_q.size() - bt, done_cnt4 - bd);
        end
        for (int d = 0; d < 4; d++) begin
            e1 = ref_lfsr[0];
            e2 = ref_lfsr[1];
            ref_lfsr = lfsr_next(ref_lfsr);
            if (bt + d < t1_q.size() && bw + d < wa_q.size()) begin
                checks++;
                if (t1_q[bt + d] !== e1 || t2_q[bt + d] !== e2 || wb_q[bw + d] !== e1 || wa_q[bw + d] !== 2'(d)) begin
                    errors++;
                    $display("FAIL ties_dim%0d: tie %b%b bit %b addr %0d required tie %b%b bit %b addr %0d", d,
                             t2_q[bt + d], t1_q[bt + d], wb_q[bw + d], wa_q[bw + d], e2, e1, e1, d);
                end
            end
        end
    endtask

    task automatic test_slow_bundler();
        int bw, bt, bu, be, n;
        bit got;
        logic e1, e2, eb;
        for (int a = 0; a < 4; a++) hv_mem[a] = 4'($urandom_range(0, 15));
        delay4 = 5; spur_on = 1'b1;
        bw = wa_q.size(); bt = t1_q.size(); bu = unstable; be = excl_err;
        run4(200, n, got);
        spur_on = 1'b0; delay4 = 1;
        checks++;
        if (!got || wa_q.size() != bw + 4) begin
            errors++;
            $display("FAIL slow_pass: done %b writes %0d required 1 4", got, wa_q.size() - bw);
        end
        for (int d = 0; d < 4; d++) begin
            e1 = ref_lfsr[0];
            e2 = ref_lfsr[1];
            ref_lfsr = lfsr_next(ref_lfsr);
            eb = resolve4(hv_mem[d], e1);
            if (bw + d < wa_q.size() && bt + d < t1_q.size()) begin
                checks++;
                if (wa_q[bw + d] !== 2'(d) || wb_q[bw + d] !== eb || t1_q[bt + d] !== e1 || t2_q[bt + d] !== e2) begin
                    errors++;
                    $display("FAIL slow_dim%0d: addr %0d bit %b tie %b%b required addr %0d bit %b tie %b%b", d,
                             wa_q[bw + d], wb_q[bw + d], t2_q[bt + d], t1_q[bt + d], d, eb, e2, e1);
                end
                if (d > 0) begin
                    checks++;
                    if (wc_q[bw + d] - wc_q[bw + d - 1] != 8) begin
                        errors++;
                        $display("FAIL slow_dim_cycles: got %0d required 8", wc_q[bw + d] - wc_q[bw + d - 1]);
                    end
                end
            end
        end
        checks++;
        if (unstable != bu || excl_err != be) begin
            errors++;
            $display("FAIL slow_stability: unstable %0d strobe_errs %0d required 0 0", unstable - bu, excl_err - be);
        end
    endtask

    task automatic test_start_abort();
        int bw, bd, bs, n, fires, busy_cnt;
        bit got;
        for (int a = 0; a < 4; a++) hv_mem[a] = 4'($urandom_range(0, 15));
        delay4 = 1;
        bw = wa_q.size(); bd = done_cnt4;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        repeat (5) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (done4) got = 1'b1;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!got || wa_q.size() != bw + 4 || done_cnt4 != bd + 1) begin
            errors++;
            $display("FAIL restart_ignored: done %b writes %0d dones %0d required 1 4 1",
                     got, wa_q.size() - bw, done_cnt4 - bd);
        end
        for (int d = 0; d < 4; d++) begin
            if (bw + d < wa_q.size()) begin
                checks++;
                if (wa_q[bw + d] !== 2'(d) || wb_q[bw + d] !== resolve4(hv_mem[d], ref_lfsr[0])) begin
                    errors++;
                    $display("FAIL restart_dim%0d: addr %0d bit %b required addr %0d bit %b", d,
                             wa_q[bw + d], wb_q[bw + d], d, resolve4(hv_mem[d], ref_lfsr[0]));
                end
            end
            ref_lfsr = lfsr_next(ref_lfsr);
        end

        bs = strobe_cnt4; busy_cnt = 0;
        @(negedge clk) begin start4 = 1'b1; abort4 = 1'b1; end
        @(negedge clk) begin start4 = 1'b0; abort4 = 1'b0; end
        repeat (5) begin
            if (busy4) busy_cnt++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != 0 || strobe_cnt4 != bs) begin
            errors++;
            $display("FAIL start_abort_idle: busy cycles %0d strobes %0d required 0 0", busy_cnt, strobe_cnt4 - bs);
        end

        delay4 = 3;
        bw = wa_q.size(); bd = done_cnt4;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        fires = 0; n = 0;
        while (fires < 3 && n < 100) begin
            if (bnd_en4) fires++;
            if (fires < 3) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (fires != 3) begin
            errors++;
            $display("FAIL abort_reach_dim2: fires %0d required 3", fires);
        end
        @(negedge clk) abort4 = 1'b1;
        @(negedge clk) abort4 = 1'b0;
        checks++;
        if ({busy4, rd_en4, bnd_en4, wr_en4, done4} !== 5'b0) begin
            errors++;
            $display("FAIL abort_next_cycle: busy/rd/bnd/wr/done %b required 00000",
                     {busy4, rd_en4, bnd_en4, wr_en4, done4});
        end
        repeat (15) @(negedge clk);
        checks++;
        if (wa_q.size() != bw + 2 || done_cnt4 != bd || busy4) begin
            errors++;
            $display("FAIL abort_aftermath: writes %0d dones %0d busy %b required 2 0 0",
                     wa_q.size() - bw, done_cnt4 - bd, busy4);
        end
        for (int d = 0; d < 3; d++) ref_lfsr = lfsr_next(ref_lfsr);
        delay4 = 1;
    endtask

    task automatic test_reset_mid();
        int bw, bt, bd, fires, n;
        bit got;
        for (int a = 0; a < 4; a++) hv_mem[a] = 4'($urandom_range(0, 15));
        delay4 = 5;
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        fires = 0; n = 0;
        while (fires < 2 && n < 100) begin
            if (bnd_en4) fires++;
            if (fires < 2) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, rd_en4, bnd_en4, wr_en4, tie1_4, tie2_4, wr_bit4, rd_addr4, wr_addr4, bb4} !== '0
            || fires != 2) begin
            errors++;
            $display("FAIL reset_mid_wait: outputs %b fires %0d required 0 and 2",
                     {busy4, done4, rd_en4, bnd_en4, wr_en4, tie1_4, tie2_4, wr_bit4, rd_addr4, wr_addr4, bb4}, fires);
        end
        bw = wa_q.size();
        @(negedge clk) nrst = 1'b1;
        ref_lfsr = SEED;
        delay4 = 1;
        repeat (8) @(negedge clk);
        checks++;
        if (wa_q.size() != bw || busy4) begin
            errors++;
            $display("FAIL reset_no_partial_write: writes %0d busy %b required 0 0", wa_q.size() - bw, busy4);
        end
        bt = t1_q.size(); bd = done_cnt4;
        run4(100, n, got);
        checks++;
        if (!got || wa_q.size() != bw + 4 || done_cnt4 != bd + 1) begin
            errors++;
            $display("FAIL reset_rerun: done %b writes %0d dones %0d required 1 4 1",
                     got, wa_q.size() - bw, done_cnt4 - bd);
        end
        for (int d = 0; d < 4; d++) begin
            if (bw + d < wa_q.size() && bt + d < t1_q.size()) begin
                checks++;
                if (wa_q[bw + d] !== 2'(d) || t1_q[bt + d] !== ref_lfsr[0] || t2_q[bt + d] !== ref_lfsr[1] ||
                    wb_q[bw + d] !== resolve4(hv_mem[d], ref_lfsr[0])) begin
                    errors++;
                    $display("FAIL reset_rerun_dim%0d: addr %0d tie %b%b bit %b required addr %0d tie %b%b bit %b", d,
                             wa_q[bw + d], t2_q[bt + d], t1_q[bt + d], wb_q[bw + d], d, ref_lfsr[1], ref_lfsr[0],
                             resolve4(hv_mem[d], ref_lfsr[0]));
                end
            end
            ref_lfsr = lfsr_next(ref_lfsr);
        end
    endtask

    initial begin
        test_reset();
        test_odd_majority();
        test_ties();
        test_slow_bundler();
        test_start_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hv_bundle_seq.md
Name: hv_bundle_seq

Overview:
Sequencer that drives one bundler_bit instance across every dimension of a DIM-bit hypervector set. It fetches NUM_HVS bits per dimension from the HV buffer and pulses the bundler. It supplies tie-break bits from an internal LFSR, waits for the bundler's done, and writes each majority bit to the result buffer. It sits between the encoder's HV buffer and the associative-memory input, and is started once per encoding window.

Parameters:
NUM_HVS, 5, number of hypervectors bundled (odd or even)
DIM, 256, hypervector dimension (bits per HV)
ADDR_W, $clog2(DIM), dimension index width
LFSR_SEED, 16'hACE1, non-zero reset seed of the 16-bit tie-break LFSR

Ports:
clk  in  1  system clock
nrst  in  1  async active-low reset
start  in  1  one-cycle request to bundle a full HV set; ignored unless IDLE
abort  in  1  return to IDLE at next edge; no done pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last dimension is written
rd_en  out  1  HV buffer read strobe
rd_addr  out  ADDR_W  dimension index to read
rd_bits  in  NUM_HVS (unpacked [NUM_HVS-1:0])  bit d of each HV; valid 1 cycle after rd_en
bnd_en  out  1  one-cycle enable to bundler_bit
bnd_bits  out  NUM_HVS (unpacked [NUM_HVS-1:0])  operand bits to bundler_bit
bnd_tie_1  out  1  tie-break bit 1
bnd_tie_2  out  1  tie-break bit 2
bnd_done  in  1  bundler result valid
bnd_out_bit  in  1  bundler majority bit
wr_en  out  1  result buffer write strobe
wr_addr  out  ADDR_W  result dimension index
wr_bit  out  1  result bit

Behaviour:
- Single clock clk. Reset nrst is asynchronous, active-low, and applies to all state.
- Reset values: state=IDLE; busy, done, rd_en, bnd_en, wr_en = 0; rd_addr, wr_addr = 0; bnd_bits all 0; bnd_tie_1, bnd_tie_2, wr_bit = 0; dim counter = 0; LFSR = LFSR_SEED.
- FSM states: IDLE, READ, FIRE, WAIT, WRITE, FIN.
- IDLE: on start, go to READ and clear the counter.
- READ: rd_en=1, rd_addr=counter, then go to FIRE.
- FIRE:
  - bnd_en=1 for exactly one cycle.
  - bnd_bits = rd_bits, registered and held stable until the next FIRE.
  - bnd_tie_1 = LFSR[0], bnd_tie_2 = LFSR[1].
  - LFSR advances by one step (taps 16,14,13,11) in this cycle only.
  - Go to WAIT.
- WAIT: hold outputs until bnd_done=1, then capture bnd_out_bit and go to WRITE. bnd_done is sampled only in WAIT; a bnd_done in any other state is ignored.
- WRITE:
  - wr_en=1, wr_addr=counter, wr_bit=captured bit.
  - If counter==DIM-1, go to FIN.
  - Otherwise counter+1, then go to READ.
- FIN: done=1 for one cycle, then go to IDLE. busy drops in the same cycle done drops.
- Latency: each dimension takes 3+k cycles, where k≥1 is the number of WAIT cycles. A full pass takes DIM·(3+k)+2 cycles from start to the done pulse.
- Counter never wraps inside a pass; it is cleared on start.
- The LFSR is not reset between passes, so tie sequences continue across windows. Only nrst reloads it.
- Tie bits are driven even when NUM_HVS is odd (the bundler ignores them then).
- start while busy: ignored, no queuing.
- abort has priority over start and over every state transition. It forces IDLE, with strobes 0 in the next cycle and no done pulse. The counter and LFSR keep their values.
- abort and start in the same cycle in IDLE: stay IDLE.
- nrst low mid-pass: immediate return to reset values. No partial write completes after reset deassertion.
- rd_en, bnd_en and wr_en are mutually exclusive and each is a single-cycle pulse.

Decomposition:
- Shared package hdc_pkg holds:
  - the state enum bundle_seq_state_t
  - LFSR tap mask constant BUNDLE_LFSR_TAPS
  - default LFSR_SEED
- One sub-module, tie_lfsr (16-bit Fibonacci LFSR with step enable and seed parameter), is natural for reuse by the even-count bundler paths.
- bundler_bit is instantiated at the level above this block, not inside it.

Test Plan:
- Reset: hold nrst=0 for 100 ns -> all outputs 0, busy=0. Release with no start -> no strobes for 20 cycles.
- DIM=4, NUM_HVS=5, rd_bits model returns 5'b01011 for every address, bundler model with done 1 cycle after en returns majority:
  - wr_bit=1 at wr_addr 0,1,2,3
  - done pulses exactly once, 18 cycles after start
  - each dimension takes 4 cycles
- DIM=4, NUM_HVS=4, rd_bits=4'b0011 at every address -> bnd_tie_1 and bnd_tie_2 match a reference LFSR from seed 16'hACE1, one step per FIRE. wr_bit equals the model's tie-resolved value.
- Bundler done delayed 5 cycles -> FSM stays in WAIT with bnd_bits stable, only one wr_en per dimension, and a spurious bnd_done injected during READ is ignored.
- start pulse during pass and start+abort in IDLE -> no restart. Later, abort at dimension 2 -> IDLE next cycle, no done, no further wr_en.
- nrst pulsed low mid-WAIT at dimension 1 -> outputs return to reset values immediately. A new start rewrites from wr_addr 0, and LFSR restarts from the seed.
